// File: rtl/csr_counters_if.sv
// CSR request/response bundle between a requester and the counter block.
// Latency: none, wires only.
// Backpressure: none; every request is acknowledged exactly one cycle later.
interface csr_counters_if;
  logic [11:0] csr_addr;
  logic        csr_rd_req;
  logic        csr_wr_req;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_ack;
  logic        csr_err;

  modport master (
    output csr_addr, csr_rd_req, csr_wr_req, csr_wdata,
    input  csr_rdata, csr_ack, csr_err
  );

  modport slave (
    input  csr_addr, csr_rd_req, csr_wr_req, csr_wdata,
    output csr_rdata, csr_ack, csr_err
  );
endinterface

// File: rtl/csr_counters.sv
// cycle/time/instret (+ optional hpm, macro CSR_COUNTERS_HPM_EN) performance counters behind a CSR port.
// Latency: request in cycle N is acknowledged in cycle N+1; reads return the value at the start of cycle N.
// Backpressure: none; a new request may be issued every cycle.
module csr_counters #(
  parameter int CNT_W    = 64,
  parameter int N_HPM    = 4,
  parameter int TIME_DIV = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_retired,
  input  logic [N_HPM-1:0] hpm_event,
  csr_counters_if.slave    bus
);

  localparam int          INH_W     = N_HPM + 3;
  localparam logic [15:0] PRESC_MAX = 16'(TIME_DIV - 1);
`ifdef CSR_COUNTERS_HPM_EN
  localparam logic [INH_W-1:0] INH_MASK = {{N_HPM{1'b1}}, 3'b101};
`else
  localparam logic [INH_W-1:0] INH_MASK = {{N_HPM{1'b0}}, 3'b101};
`endif

  logic [15:0]      presc_q;
  logic [CNT_W-1:0] cycle_q, time_q, instret_q;
  logic [INH_W-1:0] inh_q;
  logic             ack_q, err_q;
  logic [31:0]      rdata_q;

  logic [6:0]  idx;
  logic        hi, in_c, in_b, is_inh, is_hpm, mapped;
  logic        req_err, wr_ok, wr_cycle, wr_instret, wr_inh;
  logic [63:0] rd_val;
  logic [31:0] rd_word;

  // Replace one 32-bit half of a counter, leaving the other half intact.
  function automatic logic [CNT_W-1:0] merge(input logic [CNT_W-1:0] cur,
                                             input logic hsel, input logic [31:0] wd);
    logic [63:0] t;
    t = 64'(cur);
    if (hsel) t[63:32] = wd;
    else      t[31:0]  = wd;
    return t[CNT_W-1:0];
  endfunction

`ifdef CSR_COUNTERS_HPM_EN
  logic [CNT_W-1:0] hpm_q [N_HPM];
  logic [6:0]       hpm_idx;
  logic             wr_hpm;
  assign hpm_idx = idx - 7'd3;
  assign wr_hpm  = wr_ok & in_b & is_hpm;
`else
  logic unused_hpm;
  assign unused_hpm = ^hpm_event;
`endif

  // Address decode, error classification and read mux for the current request.
  always_comb begin
    idx     = bus.csr_addr[6:0];
    hi      = bus.csr_addr[7];
    in_c    = (bus.csr_addr[11:8] == 4'hC);
    in_b    = (bus.csr_addr[11:8] == 4'hB);
    is_inh  = (bus.csr_addr == 12'h320);
    is_hpm  = (idx >= 7'd3) && (idx < 7'(3 + N_HPM));
    mapped  = is_inh | ((in_c | in_b) &
              ((idx == 7'd0) | (idx == 7'd2) | is_hpm | (in_c & (idx == 7'd1))));
    rd_val  = '0;
    if (is_inh) begin
      rd_val = 64'(inh_q);
    end else if (idx == 7'd0) begin
      rd_val = 64'(cycle_q);
    end else if (idx == 7'd1) begin
      rd_val = 64'(time_q);
    end else if (idx == 7'd2) begin
      rd_val = 64'(instret_q);
    end else begin
`ifdef CSR_COUNTERS_HPM_EN
      for (int i = 0; i < N_HPM; i++)
        if (is_hpm && hpm_idx == 7'(i)) rd_val = 64'(hpm_q[i]);
`endif
    end
    rd_word    = hi ? rd_val[63:32] : rd_val[31:0];
    req_err    = ~mapped | (bus.csr_wr_req & in_c) | (bus.csr_rd_req & bus.csr_wr_req);
    wr_ok      = bus.csr_wr_req & ~req_err;
    wr_cycle   = wr_ok & in_b & (idx == 7'd0);
    wr_instret = wr_ok & in_b & (idx == 7'd2);
    wr_inh     = wr_ok & is_inh;
  end

  // Counter state: a CSR write to a counter takes priority over its increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      cycle_q   <= '0;
      time_q    <= '0;
      instret_q <= '0;
      inh_q     <= '0;
    end else begin
      presc_q <= (presc_q == PRESC_MAX) ? 16'd0 : presc_q + 16'd1;
      if (presc_q == PRESC_MAX) time_q <= time_q + CNT_W'(1);
      if (wr_cycle)        cycle_q <= merge(cycle_q, hi, bus.csr_wdata);
      else if (!inh_q[0])  cycle_q <= cycle_q + CNT_W'(1);
      if (wr_instret)      instret_q <= merge(instret_q, hi, bus.csr_wdata);
      else if (inst_retired && !inh_q[2]) instret_q <= instret_q + CNT_W'(1);
      if (wr_inh) inh_q <= bus.csr_wdata[INH_W-1:0] & INH_MASK;
    end
  end

`ifdef CSR_COUNTERS_HPM_EN
  // Event counters, same write-over-increment priority as the fixed counters.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_HPM; i++) begin
      if (rst)                                  hpm_q[i] <= '0;
      else if (wr_hpm && hpm_idx == 7'(i))      hpm_q[i] <= merge(hpm_q[i], hi, bus.csr_wdata);
      else if (hpm_event[i] && !inh_q[3 + i])   hpm_q[i] <= hpm_q[i] + CNT_W'(1);
    end
  end
`endif

  // Register the response; read data is forced to zero for writes and errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= bus.csr_rd_req | bus.csr_wr_req;
      err_q   <= (bus.csr_rd_req | bus.csr_wr_req) & req_err;
      rdata_q <= (bus.csr_rd_req & ~req_err) ? rd_word : 32'd0;
    end
  end

  // A response pending when reset arrives is suppressed rather than delivered.
  assign bus.csr_ack   = ack_q & ~rst;
  assign bus.csr_err   = err_q & ~rst;
  assign bus.csr_rdata = (ack_q & ~rst) ? rdata_q : 32'd0;

endmodule

// File: tb/tb_csr_counters.sv
// Scoreboard bench for csr_counters: directed requests push expected responses, a monitor checks them.
// Latency: expects every accepted request to be acknowledged exactly one cycle later.
// Backpressure: none; requests are issued back-to-back where useful.
module tb_csr_counters;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inst_retired = 1'b0;
  logic [3:0] hpm_event = '0;

  csr_counters_if bus();

  csr_counters #(.CNT_W(64), .N_HPM(4), .TIME_DIV(100)) dut (
    .clk(clk), .rst(rst), .inst_retired(inst_retired), .hpm_event(hpm_event), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        chkd;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  logic req_seen = 1'b0;

`ifdef CSR_COUNTERS_HPM_EN
  localparam logic [31:0] HPM_EXP7  = 32'd7;
  localparam logic [31:0] HPM_EXPW  = 32'h1234;
  localparam logic [31:0] INH_RBACK = 32'h7D;
`else
  localparam logic [31:0] HPM_EXP7  = 32'd0;
  localparam logic [31:0] HPM_EXPW  = 32'd0;
  localparam logic [31:0] INH_RBACK = 32'h05;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, expv);
    end
  endtask

  // Drive one request for exactly one cycle; caller is aligned 1ns after a rising edge.
  task automatic op(input logic [11:0] a, input logic rd, input logic wr, input logic [31:0] wd,
                    input logic push, input logic chkd, input logic [31:0] ed, input logic ee,
                    input string nm);
    exp_t e;
    bus.csr_addr   = a;
    bus.csr_rd_req = rd;
    bus.csr_wr_req = wr;
    bus.csr_wdata  = wd;
    if (push) begin
      e.data = ed; e.err = ee; e.chkd = chkd; e.name = nm;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.csr_rd_req = 1'b0;
    bus.csr_wr_req = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] ed, input logic ee, input string nm);
    op(a, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1, ed, ee, nm);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] wd, input logic ee, input string nm);
    op(a, 1'b0, 1'b1, wd, 1'b1, 1'b0, 32'd0, ee, nm);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Note which edges captured a live request.
  always @(posedge clk) req_seen <= (bus.csr_rd_req | bus.csr_wr_req) & ~rst;

  // Monitor: ack timing against captured requests, response contents against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if ((req_seen & ~rst) || bus.csr_ack)
      chk("ack_timing", 32'(bus.csr_ack), 32'(req_seen & ~rst));
    if (bus.csr_ack) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk({e.name, "_err"}, 32'(bus.csr_err), 32'(e.err));
        if (e.chkd || e.err) chk({e.name, "_rdata"}, bus.csr_rdata, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.csr_addr = '0; bus.csr_rd_req = 1'b0; bus.csr_wr_req = 1'b0; bus.csr_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack",   32'(bus.csr_ack), 32'd0);
    chk("rst_err",   32'(bus.csr_err), 32'd0);
    chk("rst_rdata", bus.csr_rdata,    32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Time prescaler: 250 cycles after reset gives two ticks.
    idle(250);
    rd(12'hC01, 32'd2,   1'b0, "time_250");
    rd(12'hC00, 32'd251, 1'b0, "cycle_b2b");
    rd(12'hC80, 32'd0,   1'b0, "cycle_hi");

    // Full 64-bit wrap of cycle.
    wr(12'hB00, 32'hFFFF_FFFF, 1'b0, "wr_mcycle_lo");
    wr(12'hB80, 32'hFFFF_FFFF, 1'b0, "wr_mcycle_hi");
    idle(1);
    rd(12'hC80, 32'd0, 1'b0, "cycle_wrap_hi");
    rd(12'hC00, 32'd1, 1'b0, "cycle_wrap_lo");

    // Inhibit freezes cycle after the write edge; bit 1 and unimplemented bits read 0.
    wr(12'h320, 32'h1, 1'b0, "wr_inhibit");
    idle(10);
    rd(12'hC00, 32'd3, 1'b0, "cycle_frozen_a");
    idle(4);
    rd(12'hC00, 32'd3, 1'b0, "cycle_frozen_b");
    rd(12'h320, 32'h1, 1'b0, "inhibit_rd");
    wr(12'h320, 32'hFFFF_FFFF, 1'b0, "wr_inhibit_all");
    rd(12'h320, INH_RBACK, 1'b0, "inhibit_mask");
    wr(12'h320, 32'h0, 1'b0, "wr_inhibit_clr");

    // instret: counting, illegal writes, write-over-increment.
    wr(12'hB02, 32'h10, 1'b0, "wr_minstret");
    inst_retired = 1'b1;
    idle(3);
    inst_retired = 1'b0;
    wr(12'hC02, 32'h55, 1'b1, "wr_ro_instret");
    rd(12'hC02, 32'h13, 1'b0, "instret_a");
    op(12'hB02, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 32'd0, 1'b1, "rd_wr_both");
    rd(12'hC02, 32'h13, 1'b0, "instret_kept");
    inst_retired = 1'b1;
    wr(12'hB02, 32'h100, 1'b0, "wr_minstret_race");
    inst_retired = 1'b0;
    rd(12'hC02, 32'h100, 1'b0, "instret_wr_wins");
    rd(12'hC82, 32'h0,   1'b0, "instret_hi");
    rd(12'hB01, 32'h0,   1'b1, "unmapped_b01");
    rd(12'h123, 32'h0,   1'b1, "unmapped_123");
    rd(12'hC07, 32'h0,   1'b1, "unmapped_hpm7");

    // hpm[1]: seven events, then a write to the low half.
    hpm_event = 4'b0010;
    idle(7);
    hpm_event = 4'b0000;
    rd(12'hC04, HPM_EXP7, 1'b0, "hpm1_count");
    rd(12'hC84, 32'h0,    1'b0, "hpm1_hi");
    wr(12'hB04, 32'h1234, 1'b0, "wr_mhpm1");
    rd(12'hC04, HPM_EXPW, 1'b0, "hpm1_written");

    // A read caught by reset is never acknowledged; everything restarts from zero.
    op(12'hC00, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, "rd_before_rst");
    rst = 1'b1;
    @(negedge clk);
    chk("ack_under_rst", 32'(bus.csr_ack), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    rd(12'hC00, 32'd0, 1'b0, "post_rst_cycle");
    rd(12'hC01, 32'd0, 1'b0, "post_rst_time");
    rd(12'hC02, 32'd0, 1'b0, "post_rst_instret");
    rd(12'hC04, 32'd0, 1'b0, "post_rst_hpm1");
    rd(12'h320, 32'd0, 1'b0, "post_rst_inhibit");

    idle(3);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/csr_counters.md
CSR_COUNTERS -- requirements
Module: csr_counters

Interface
REQ-001 Parameter CNT_W, default 64, counter width in bits (legal 33..64).
REQ-002 Parameter N_HPM, default 4, number of hardware event counters (legal 1..8).
REQ-003 Parameter TIME_DIV, default 100, clk cycles per time tick (legal 2..65535).
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 csr_addr  input  12  CSR address of request.
REQ-008 csr_rd_req  input  1  single-cycle read request.
REQ-009 csr_wr_req  input  1  single-cycle write request.
REQ-010 csr_wdata  input  32  write data.
REQ-011 inst_retired  input  1  one instruction retired this cycle.
REQ-012 hpm_event  input  N_HPM  per-counter event strobe.
REQ-013 csr_rdata  output  32  read data, valid while csr_ack high.
REQ-014 csr_ack  output  1  one-cycle completion pulse.
REQ-015 csr_err  output  1  illegal access flag, valid with csr_ack.

Function
REQ-016 Counters cycle, time, instret and hpm[i] shall each be CNT_W bits and wrap from all-ones to zero.
REQ-017 Address map: low halves 0xC00 cycle, 0xC01 time, 0xC02 instret, 0xC03+i hpm[i]; high halves at same offset +0x080; writable aliases 0xB00 mcycle, 0xB02 minstret, 0xB03+i mhpm[i], high halves +0x080; 0x320 mcountinhibit.
REQ-018 cycle shall increment every cycle unless mcountinhibit[0]=1.
REQ-019 Prescaler shall count 0..TIME_DIV-1; time shall increment on the cycle prescaler wraps, giving exactly one tick per TIME_DIV cycles; time is not inhibitable and not writable.
REQ-020 instret shall increment when inst_retired=1 and mcountinhibit[2]=0; hpm[i] when hpm_event[i]=1 and mcountinhibit[3+i]=0.
REQ-021 mcountinhibit shall be 3+N_HPM bits; bit 1 and unimplemented bits read 0 and ignore writes.
REQ-022 A request accepted in cycle N shall produce csr_ack=1 in cycle N+1 only; back-to-back requests every cycle shall be supported.
REQ-023 Read data shall be the counter value at the start of cycle N; high-half bits above CNT_W read 0.
REQ-024 Write to a low half shall replace bits [31:0]; to a high half bits [CNT_W-1:32]; other half unchanged.
REQ-025 Write and increment of the same counter in one cycle: written value shall win, increment lost.
REQ-026 csr_err=1 with ack for: unmapped address, write to 0xC00-0xCFF range, or csr_rd_req and csr_wr_req both high; errored writes shall not modify state.
REQ-027 csr_rdata shall be 0 whenever csr_ack=0 or csr_err=1.

Reset
REQ-028 rst=1 shall clear all counters, prescaler and mcountinhibit to 0 on the next edge.
REQ-029 Outputs after reset edge: csr_ack=0, csr_err=0, csr_rdata=0.
REQ-030 A request accepted in the cycle before rst is asserted shall not be acknowledged; requests while rst=1 are ignored.

Configuration
REQ-031 Macro CSR_COUNTERS_HPM_EN defined: hpm counters, their addresses and mcountinhibit[3+:N_HPM] implemented as above.
REQ-032 Macro absent: no hpm storage; hpm addresses read 0 without error, writes ack without error and are discarded, mcountinhibit[3+:N_HPM] read 0.

Verification
REQ-033 Reset, run 250 cycles, read 0xC01 -> rdata=2 (TIME_DIV=100), ack exactly one cycle after request.
REQ-034 Write 0xB00=0xFFFFFFFF and 0xB80=0xFFFFFFFF, idle 1 cycle, read 0xC80 -> 0x00000000 (wrapped).
REQ-035 Write 0x320=0x1, wait 10 cycles, read 0xC00 twice 5 cycles apart -> identical values.
REQ-036 Write 0xC02 -> csr_err=1, instret unchanged; rd+wr same cycle -> csr_err=1.
REQ-037 hpm_event[1] pulsed 7 times, read 0xC04 -> 7 with macro defined, 0 and csr_err=0 without.
REQ-038 Issue read, assert rst next cycle -> csr_ack stays 0; all counters read 0 afterwards.
